dest_reg_hazard_unit: RTL
=========================

// Module: dest_reg_hazard_unit
// PURPOSE
//  Consumes the 5-bit destination-register number picked by the EX-stage
//  rt/rd select, plus the RegWrite/MemRead controls of the same instruction.
//  Tracks that destination through the MEM and WB stages in its own registers.
//  Produces two outputs for the ID/EX datapath: EX operand forwarding selects,
//  and a load-use stall request.
//  Keeps a saturating count of stall cycles for debug.
// PARAMETERS
//  REG_W   5   register-number width (32-entry register file)
//  CNT_W   16  width of the stall-cycle counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      async reset, active-high
//  ex_wreg     in   REG_W  destination register of the EX instruction (mux result)
//  ex_regwrite in   1      EX instruction writes the register file
//  ex_memread  in   1      EX instruction is a load
//  ex_valid    in   1      EX holds a real instruction (0 = bubble)
//  ex_kill     in   1      squash the EX instruction; it never reaches MEM
//  ex_rs       in   REG_W  EX operand A source register
//  ex_rt       in   REG_W  EX operand B source register
//  id_rs       in   REG_W  ID source register A
//  id_rt       in   REG_W  ID source register B
//  id_use_rs   in   1      ID instruction reads rs
//  id_use_rt   in   1      ID instruction reads rt
//  fwd_a       out  2      operand A select: 00 regfile, 10 MEM result, 01 WB result
//  fwd_b       out  2      operand B select, same encoding
//  stall       out  1      hold PC and IF/ID; insert a bubble into ID/EX
//  wb_wreg     out  REG_W  registered WB-stage destination (for regfile write)
//  wb_regwrite out  1      registered WB-stage write enable
//  stall_cnt   out  CNT_W  saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset:
//   - rst=1 clears mem_wreg, mem_regwrite, mem_memread, wb_wreg, wb_regwrite and stall_cnt to 0.
//   - While rst=1: stall=0, fwd_a=00, fwd_b=00.
//  Stage shift (each rising clk, rst=0):
//   - MEM <= EX record, but only if ex_valid=1 and ex_kill=0.
//   - Otherwise MEM <= bubble (regwrite=0, memread=0, wreg=0).
//   - WB <= MEM unconditionally.
//   - Latency: EX -> MEM is 1 cycle; EX -> WB is 2 cycles.
//   - stall does not freeze the tracker. The upstream bubble arrives via ex_valid=0.
//  Forwarding (combinational from registered MEM/WB state):
//   - fwd_a=10 if mem_regwrite and mem_wreg!=0 and mem_wreg==ex_rs.
//   - Else fwd_a=01 if wb_regwrite and wb_wreg!=0 and wb_wreg==ex_rs.
//   - Else fwd_a=00.
//   - fwd_b is the same, using ex_rt.
//   - When MEM and WB both match, MEM wins (it is the younger producer).
//   - Register 0 is never forwarded.
//  Load-use stall (combinational):
//   - stall=1 when ALL of these hold: ex_valid, ~ex_kill, ex_memread, ex_regwrite, ex_wreg!=0.
//   - AND at least one of: (id_use_rs and id_rs==ex_wreg) or (id_use_rt and id_rt==ex_wreg).
//   - One stall cycle per load-use pair. On the next cycle the load is in MEM and EX holds the
//     bubble, so stall drops on its own.
//   - The consumer then reaches EX with the load in WB, and gets fwd=01.
//   - A load in MEM never drives fwd=10 with stale data: the one-cycle stall guarantees this.
//  Counter:
//   - stall_cnt increments on each rising clk where stall=1.
//   - Holds at all-ones (no wrap).
//  Mid-operation reset:
//   - Asynchronous. In-flight MEM/WB records are discarded immediately.
//   - No forwarding from pre-reset state.
// TESTING
//  1. rst pulse mid-stream with MEM/WB loaded -> outputs immediately 0; stall_cnt=0; fwd=00.
//  2. EX: add $8 (regwrite=1). Next cycle ex_rs=8 -> fwd_a=10.
//     Following cycle ex_rt=8 -> fwd_b=01; wb_wreg=8, wb_regwrite=1.
//  3. EX lw $9, ID id_rs=9 id_use_rs=1 -> stall=1 for exactly 1 cycle.
//     Then with ex_valid=0, stall=0; consumer in EX ex_rs=9 -> fwd_a=01; stall_cnt=1.
//  4. MEM and WB both write $5, ex_rs=ex_rt=5 -> fwd_a=fwd_b=10.
//     Any write to $0 with ex_rs=0 -> fwd_a=00; lw $0 vs id_rs=0 -> stall=0.
//  5. ex_kill=1 on add $7, then ex_rs=7 next cycle -> fwd_a=00; wb_regwrite stays 0.
//  6. Force stall for 2^CNT_W+3 cycles (CNT_W=4 override) -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/dest_reg_hazard_unit.sv
// dest_reg_hazard_unit
//   Tracks the destination register of the EX instruction through MEM and WB.
//   From that tracked state it produces the EX operand forwarding selects and
//   a load-use stall request. It also keeps a saturating count of stall cycles.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   ex_wreg/ex_regwrite/     EX instruction destination and its controls
//   ex_memread/ex_valid/
//   ex_kill
//   ex_rs, ex_rt             EX operand source registers (forwarding compare)
//   id_rs, id_rt,            ID source registers and their use flags (stall compare)
//   id_use_rs, id_use_rt
//   fwd_a, fwd_b             00 regfile, 10 MEM result, 01 WB result
//   stall                    hold PC and IF/ID; insert a bubble into ID/EX
//   wb_wreg, wb_regwrite     registered WB-stage write port controls
//   stall_cnt                saturating count of cycles with stall=1
module dest_reg_hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_valid,
    input  logic             ex_kill,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [REG_W-1:0] wb_wreg,
    output logic             wb_regwrite,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [REG_W-1:0] mem_wreg;
    logic             mem_regwrite;
    logic             mem_memread;
    logic             ex_live;
    logic             ex_is_load;
    logic             rs_hit;
    logic             rt_hit;

    assign ex_live = ex_valid & ~ex_kill;

    // Stage tracker: a squashed or empty EX slot enters MEM as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wreg     <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            wb_wreg      <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            if (ex_live) begin
                mem_wreg     <= ex_wreg;
                mem_regwrite <= ex_regwrite;
                mem_memread  <= ex_memread;
            end else begin
                mem_wreg     <= '0;
                mem_regwrite <= 1'b0;
                mem_memread  <= 1'b0;
            end
            wb_wreg     <= mem_wreg;
            wb_regwrite <= mem_regwrite;
        end
    end

    // Forwarding selects; MEM is the younger producer so it is checked first.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst) begin
            if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rs)) begin
                fwd_a = FWD_MEM;
            end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rs)) begin
                fwd_a = FWD_WB;
            end
            if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == ex_rt)) begin
                fwd_b = FWD_MEM;
            end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == ex_rt)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // Load-use detection against the instruction sitting in ID.
    always_comb begin
        ex_is_load = ex_live & ex_memread & ex_regwrite & (ex_wreg != '0);
        rs_hit     = id_use_rs & (id_rs == ex_wreg);
        rt_hit     = id_use_rt & (id_rt == ex_wreg);
        stall      = ~rst & ex_is_load & (rs_hit | rt_hit);
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // A load still in MEM has no data yet; the stall must keep it from feeding EX.
    a_no_load_fwd_from_mem: assert property (@(posedge clk) disable iff (rst)
        !(ex_valid && mem_regwrite && mem_memread && ((fwd_a == FWD_MEM) || (fwd_b == FWD_MEM))));

endmodule
